register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank_pkg.sv | 13 +
 rtl/register_bank_register64bit.sv | 30 +++
 rtl/register_bank.sv | 62 ++++++
 tb/tb_register_bank.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Shared sizing, the zero-register constant and data/address types for the
// 64-bit register bank.
package register_bank_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int ZERO_REG = NUM_REGS - 1;

  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage : register_bank_pkg

// File: rtl/register_bank_register64bit.sv
// DATA_W-wide enabled register assembled from one-bit enabled cells with an
// asynchronous active-low clear.
module register64bit #(
  parameter int DATA_W = register_bank_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    logic bit_d;
    logic bit_q;

    always_comb begin
      bit_d = bit_q;
      if (en) bit_d = d[b];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bit_q <= 1'b0;
      else        bit_q <= bit_d;
    end

    assign q[b] = bit_q;
  end

endmodule : register64bit

// File: rtl/register_bank.sv
// Register file with 31 stored registers, a hard-wired zero register at the
// top address, one-hot write decode and two bypassing combinational reads.
module register_bank #(
  parameter int DATA_W   = register_bank_pkg::DATA_W,
  parameter int NUM_REGS = register_bank_pkg::NUM_REGS,
  parameter int ADDR_W   = register_bank_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  import register_bank_pkg::ZERO_REG;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic              write_ok;
  logic [NUM_REGS-2:0] wr_en;
  logic [DATA_W-1:0]   reg_val [NUM_REGS-1];

  assign write_ok = RegWrite && (WriteRegister != ZERO_ADDR);

  always_comb begin
    wr_en = '0;
    if (write_ok) wr_en[WriteRegister] = 1'b1;
  end

  for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_reg
    register64bit #(.DATA_W(DATA_W)) u_reg (
      .clk   (clk),
      .rst_n (rst),
      .en    (wr_en[r]),
      .d     (WriteData),
      .q     (reg_val[r])
    );
  end

  // Bypass forwards the pending write; holding reset forces both ports to 0.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadRegister1 != ZERO_ADDR) begin
      ReadData1 = reg_val[ReadRegister1];
      if (write_ok && (WriteRegister == ReadRegister1)) ReadData1 = WriteData;
    end
    if (ReadRegister2 != ZERO_ADDR) begin
      ReadData2 = reg_val[ReadRegister2];
      if (write_ok && (WriteRegister == ReadRegister2)) ReadData2 = WriteData;
    end
    if (!rst) begin
      ReadData1 = '0;
      ReadData2 = '0;
    end
  end

endmodule : register_bank

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank: reset, writes, zero register,
// enable gating, bypass, back-to-back writes and a full address sweep.
module tb_register_bank;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  int checks;
  int failures;

  register_bank dut (
    .clk           (clk),
    .rst           (rst),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one write ending at the next rising edge; outputs are settled at return.
  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = addr;
    WriteData     = data;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 64'hFEED;
    ReadRegister1 = 5'd4; ReadRegister2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ReadData1 !== 64'd0) begin
      failures++;
      $display("[TB] FAIL reset_bypass_suppressed actual=%h required=%h", ReadData1, 64'd0);
    end
    checks++;
    if (ReadData2 !== 64'd0) begin
      failures++;
      $display("[TB] FAIL reset_x0 actual=%h required=%h", ReadData2, 64'd0);
    end
    @(negedge clk);
    RegWrite = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (ReadData1 !== 64'd0) begin
      failures++;
      $display("[TB] FAIL reset_write_ignored actual=%h required=%h", ReadData1, 64'd0);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd7, 64'h0123_4567_89AB_CDEF);
    ReadRegister1 = 5'd7; ReadRegister2 = 5'd6;
    #1;
    checks++;
    if (ReadData1 !== 64'h0123_4567_89AB_CDEF) begin
      failures++;
      $display("[TB] FAIL write_read_x7 actual=%h required=%h", ReadData1, 64'h0123_4567_89AB_CDEF);
    end
    checks++;
    if (ReadData2 !== 64'd0) begin
      failures++;
      $display("[TB] FAIL write_read_x6 actual=%h required=%h", ReadData2, 64'd0);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'hDEAD_BEEF;
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
    #1;
    checks++;
    if (ReadData1 !== 64'd0) begin
      failures++;
      $display("[TB] FAIL zero_before_edge actual=%h required=%h", ReadData1, 64'd0);
    end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    checks++;
    if (ReadData1 !== 64'd0) begin
      failures++;
      $display("[TB] FAIL zero_after_edge actual=%h required=%h", ReadData1, 64'd0);
    end
    checks++;
    if (ReadData2 !== 64'd0) begin
      failures++;
      $display("[TB] FAIL zero_port2 actual=%h required=%h", ReadData2, 64'd0);
    end
  endtask

  task automatic test_enable_off();
    do_write(5'd3, 64'h11);
    @(negedge clk);
    RegWrite = 1'b0; WriteRegister = 5'd3; WriteData = 64'h55;
    ReadRegister1 = 5'd3;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ReadData1 !== 64'h11) begin
      failures++;
      $display("[TB] FAIL enable_off_x3 actual=%h required=%h", ReadData1, 64'h11);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 64'hA5A5;
    ReadRegister1 = 5'd10; ReadRegister2 = 5'd10;
    #1;
    checks++;
    if (ReadData1 !== 64'hA5A5) begin
      failures++;
      $display("[TB] FAIL bypass_port1 actual=%h required=%h", ReadData1, 64'hA5A5);
    end
    checks++;
    if (ReadData2 !== 64'hA5A5) begin
      failures++;
      $display("[TB] FAIL bypass_port2 actual=%h required=%h", ReadData2, 64'hA5A5);
    end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    checks++;
    if (ReadData1 !== 64'hA5A5) begin
      failures++;
      $display("[TB] FAIL bypass_stored actual=%h required=%h", ReadData1, 64'hA5A5);
    end
  endtask

  task automatic test_back_to_back();
    ReadRegister1 = 5'd12; ReadRegister2 = 5'd7;
    do_write(5'd12, 64'h1111_2222_3333_4444);
    do_write(5'd12, 64'h9999_8888_7777_6666);
    #1;
    checks++;
    if (ReadData1 !== 64'h9999_8888_7777_6666) begin
      failures++;
      $display("[TB] FAIL back_to_back_x12 actual=%h required=%h", ReadData1, 64'h9999_8888_7777_6666);
    end
    checks++;
    if (ReadData2 !== 64'h0123_4567_89AB_CDEF) begin
      failures++;
      $display("[TB] FAIL back_to_back_x7_hold actual=%h required=%h", ReadData2, 64'h0123_4567_89AB_CDEF);
    end
  endtask

  task automatic test_sweep();
    logic [DATA_W-1:0] exp1;
    logic [DATA_W-1:0] exp2;
    for (int i = 0; i < 31; i++) do_write(ADDR_W'(i), 64'(i) * 64'h1000_0001);
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      ReadRegister1 = ADDR_W'(i);
      ReadRegister2 = ADDR_W'(30 - i);
      exp1 = 64'(i) * 64'h1000_0001;
      exp2 = 64'(30 - i) * 64'h1000_0001;
      #1;
      checks++;
      if (ReadData1 !== exp1) begin
        failures++;
        $display("[TB] FAIL sweep_port1 addr=%0d actual=%h required=%h", i, ReadData1, exp1);
      end
      checks++;
      if (ReadData2 !== exp2) begin
        failures++;
        $display("[TB] FAIL sweep_port2 addr=%0d actual=%h required=%h", 30 - i, ReadData2, exp2);
      end
    end
    ReadRegister1 = 5'd31;
    #1;
    checks++;
    if (ReadData1 !== 64'd0) begin
      failures++;
      $display("[TB] FAIL sweep_x31 actual=%h required=%h", ReadData1, 64'd0);
    end
  endtask

  task automatic test_async_reset();
    do_write(5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd20;
    #1;
    checks++;
    if (ReadData1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL async_pre_x5 actual=%h required=%h", ReadData1, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ReadData1 !== 64'd0) begin
      failures++;
      $display("[TB] FAIL async_clear_x5 actual=%h required=%h", ReadData1, 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ReadData2 !== 64'd0) begin
      failures++;
      $display("[TB] FAIL async_cleared_x20 actual=%h required=%h", ReadData2, 64'd0);
    end
    do_write(5'd5, 64'h0000_0000_0000_0ABC);
    #1;
    checks++;
    if (ReadData1 !== 64'h0ABC) begin
      failures++;
      $display("[TB] FAIL async_first_write actual=%h required=%h", ReadData1, 64'h0ABC);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_enable_off();
    test_bypass();
    test_back_to_back();
    test_sweep();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_bank
